// File: rtl/mathbox_alu_array_if.sv
// Microcode-side bus of the math-box ALU: control/operand inputs plus Y, flags and EDB readback.
interface mathbox_alu_array_if #(
    parameter int W   = 16,
    parameter int DW  = 8,
    parameter int BSW = 1
);
    logic           STEP;
    logic [8:0]     I;
    logic [3:0]     A_ADDR;
    logic [3:0]     B_ADDR;
    logic           C_IN;
    logic           R15;
    logic           Q0;
    logic [DW-1:0]  EDB_IN;
    logic [BSW-1:0] BYTE_SEL;
    logic           YLO_N;
    logic           YHI_N;
    logic           STAT_LD;
    logic [DW-1:0]  EDB_OUT;
    logic           S0;
    logic           S1;
    logic [3:0]     STATUS;
    logic [W-1:0]   Y;

    modport master (
        output STEP, I, A_ADDR, B_ADDR, C_IN, R15, Q0, EDB_IN, BYTE_SEL, YLO_N, YHI_N, STAT_LD,
        input  EDB_OUT, S0, S1, STATUS, Y
    );
    modport slave (
        input  STEP, I, A_ADDR, B_ADDR, C_IN, R15, Q0, EDB_IN, BYTE_SEL, YLO_N, YHI_N, STAT_LD,
        output EDB_OUT, S0, S1, STATUS, Y
    );
endinterface

// File: rtl/mathbox_alu_array.sv
// W-bit 2901-style ALU: 16-word RAM, Q register, source/function/destination decode,
// stepped writes, latched status and registered nibble-gated readback onto the EDB.
module mathbox_alu_array #(
    parameter int W   = 16,
    parameter int DW  = 8,
    parameter int BSW = 1
) (
    input logic              CLK,
    input logic              rst_n,
    mathbox_alu_array_if.slave bus
);
    localparam int NB = W / DW;

    logic [W-1:0]  ram_q [16];
    logic [W-1:0]  q_q;
    logic [3:0]    status_q;
    logic [DW-1:0] edb_q;

    logic [2:0]    src, fn, dst;
    logic [W-1:0]  a_w, b_w, d_w, r_w, s_w, f_w, y_w;
    logic [W-1:0]  opa, opb;
    logic          arith;
    logic [W:0]    sum_w;
    logic [W-1:0]  low_w;
    logic          cout, ovr, zero;
    logic          ram_wr;
    logic [W-1:0]  ram_d, q_d;
    logic [DW-1:0] yb, edb_d;

    assign src = bus.I[2:0];
    assign fn  = bus.I[5:3];
    assign dst = bus.I[8:6];
    assign a_w = ram_q[bus.A_ADDR];
    assign b_w = ram_q[bus.B_ADDR];
    assign d_w = {NB{bus.EDB_IN}};

    always_comb begin
        r_w = '0;
        s_w = '0;
        unique case (src)
            3'd0: begin r_w = a_w; s_w = q_q; end
            3'd1: begin r_w = a_w; s_w = b_w; end
            3'd2: s_w = q_q;
            3'd3: s_w = b_w;
            3'd4: s_w = a_w;
            3'd5: begin r_w = d_w; s_w = a_w; end
            3'd6: begin r_w = d_w; s_w = q_q; end
            default: r_w = d_w;
        endcase
    end

    // Subtractions become an add of the one's complement; C_IN supplies the +1.
    always_comb begin
        opa   = r_w;
        opb   = s_w;
        arith = 1'b1;
        unique case (fn)
            3'd0: ;
            3'd1: begin opa = s_w; opb = ~r_w; end
            3'd2: opb = ~s_w;
            default: arith = 1'b0;
        endcase
    end

    assign sum_w = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, bus.C_IN};
    assign low_w = {1'b0, opa[W-2:0]} + {1'b0, opb[W-2:0]} + {{(W-1){1'b0}}, bus.C_IN};

    always_comb begin
        f_w = sum_w[W-1:0];
        unique case (fn)
            3'd3: f_w = r_w | s_w;
            3'd4: f_w = r_w & s_w;
            3'd5: f_w = ~r_w & s_w;
            3'd6: f_w = r_w ^ s_w;
            3'd7: f_w = ~(r_w ^ s_w);
            default: ;
        endcase
    end

    assign cout = arith & sum_w[W];
    assign ovr  = arith & (low_w[W-1] ^ sum_w[W]);
    assign zero = (f_w == '0);
    assign y_w  = (dst == 3'd2) ? a_w : f_w;

    // Shift destinations read q_q before the edge, so RAM/Q linkage sees the old Q.
    always_comb begin
        ram_wr = 1'b0;
        ram_d  = f_w;
        q_d    = q_q;
        unique case (dst)
            3'd0: q_d = f_w;
            3'd1: ;
            3'd2, 3'd3: ram_wr = 1'b1;
            3'd4: begin
                ram_wr = 1'b1;
                ram_d  = {bus.R15, f_w[W-1:1]};
                q_d    = {f_w[0], q_q[W-1:1]};
            end
            3'd5: begin
                ram_wr = 1'b1;
                ram_d  = {bus.R15, f_w[W-1:1]};
            end
            3'd6: begin
                ram_wr = 1'b1;
                ram_d  = {f_w[W-2:0], q_q[W-1]};
                q_d    = {q_q[W-2:0], bus.Q0};
            end
            default: begin
                ram_wr = 1'b1;
                ram_d  = {f_w[W-2:0], q_q[W-1]};
            end
        endcase
    end

    // Out-of-range byte selects fall back to byte 0.
    always_comb begin
        yb = y_w[DW-1:0];
        for (int k = 1; k < NB; k++)
            if (int'(bus.BYTE_SEL) == k) yb = y_w[k*DW +: DW];
    end

    assign edb_d[DW/2-1:0]  = bus.YLO_N ? bus.EDB_IN[DW/2-1:0]  : yb[DW/2-1:0];
    assign edb_d[DW-1:DW/2] = bus.YHI_N ? bus.EDB_IN[DW-1:DW/2] : yb[DW-1:DW/2];

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) ram_q[i] <= '0;
            q_q      <= '0;
            status_q <= '0;
            edb_q    <= '0;
        end else begin
            edb_q <= edb_d;
            if (bus.STEP) begin
                if (ram_wr) ram_q[bus.B_ADDR] <= ram_d;
                q_q <= q_d;
                if (bus.STAT_LD) status_q <= {cout, ovr, f_w[W-1], zero};
            end
        end
    end

    assign bus.Y       = y_w;
    assign bus.S0      = ovr;
    assign bus.S1      = f_w[W-1];
    assign bus.STATUS  = status_q;
    assign bus.EDB_OUT = edb_q;
endmodule

// File: doc/mathbox_alu_array.md
Name: mathbox_alu_array

Overview:
- Parametrised successor to the Tempest math-box four-slice 2901 cascade.
- Implements a W-bit bit-slice ALU with 16-word register file, Q register, 2901 source/function/destination decode, and full-width shift linkage (R15 in at the top, Q0 in at the bottom, Q MSB looped into RAM LSB).
- Adds a clock-enable step, a registered status latch, and a registered byte/nibble readback onto the 8-bit EDB.
- Sits between the math-box microcode ROMs and the EDB.

Parameters:
W, 16, ALU width in bits; multiple of 8, 8..32.
DW, 8, EDB width; W/DW is the number of readback bytes.
BSW, 1, width of BYTE_SEL, equal to clog2(W/DW) and minimum 1.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  synchronous active-low reset.
STEP  in  1  clock enable for RAM, Q and status writes.
I  in  9  microinstruction: [2:0] source, [5:3] function, [8:6] destination.
A_ADDR  in  4  RAM A read address.
B_ADDR  in  4  RAM B read/write address.
C_IN  in  1  carry into bit 0.
R15  in  1  RAM MSB shift-in on down shifts.
Q0  in  1  Q LSB shift-in on up shifts.
EDB_IN  in  DW  data bus in; replicated W/DW times to form the D operand.
BYTE_SEL  in  BSW  selects which Y byte is returned on EDB.
YLO_N  in  1  active-low enable, low nibble of the selected byte.
YHI_N  in  1  active-low enable, high nibble of the selected byte.
STAT_LD  in  1  latch the flags when STEP=1.
EDB_OUT  out  DW  registered readback.
S0  out  1  combinational overflow of the current F.
S1  out  1  combinational F[W-1].
STATUS  out  4  registered {carry, overflow, sign, zero}.
Y  out  W  combinational Y.

Behaviour:
- Reset: when rst_n=0 at a CLK edge, clear all 16 RAM words, Q, STATUS and EDB_OUT to 0. Reset overrides STEP. A reset mid-sequence discards any in-flight write.
- Operand sources (R,S) by I[2:0]:
  - 0: A,Q
  - 1: A,B
  - 2: 0,Q
  - 3: 0,B
  - 4: 0,A
  - 5: D,A
  - 6: D,Q
  - 7: D,0
- Functions by I[5:3]:
  - 0: R+S+C_IN
  - 1: S-R-1+C_IN
  - 2: R-S-1+C_IN
  - 3: R|S
  - 4: R&S
  - 5: ~R&S
  - 6: R^S
  - 7: ~(R^S)
- Arithmetic rules:
  - Arithmetic is W+1 bits wide; carry is bit W.
  - Overflow is the carry into MSB XOR the carry out of MSB.
  - For logic functions, carry=0 and overflow=0.
  - Zero is asserted when F==0.
- Destinations by I[8:6]:
  - 0: Q<=F, Y=F
  - 1: no write, Y=F
  - 2: RAM[B]<=F, Y=A
  - 3: RAM[B]<=F, Y=F
  - 4: RAM[B]<={R15,F[W-1:1]}, Q<={F[0],Q[W-1:1]}, Y=F
  - 5: RAM[B]<={R15,F[W-1:1]}, Y=F
  - 6: RAM[B]<={F[W-2:0],Q[W-1]}, Q<={Q[W-2:0],Q0}, Y=F
  - 7: RAM[B]<={F[W-2:0],Q[W-1]}, Y=F
  - Destinations 4 and 6 use the Q value from before the edge.
- Writes occur only on an edge with STEP=1. RAM reads are combinational, so a read of the address being written returns the old value until the edge.
- A_ADDR==B_ADDR is legal. The write uses the F computed from the pre-edge value.
- STATUS <= {carry, ovr, F[W-1], zero} on an edge with STEP=1 and STAT_LD=1; otherwise it holds.
- Readback is registered, one-cycle latency, and updates every edge regardless of STEP:
  - Let yb = Y[BYTE_SEL*8 +: 8].
  - EDB_OUT[3:0] <= YLO_N ? EDB_IN[3:0] : yb[3:0].
  - EDB_OUT[7:4] <= YHI_N ? EDB_IN[7:4] : yb[7:4].
  - With both enables high, EDB_OUT is a one-cycle-delayed EDB_IN.
- BYTE_SEL >= W/DW selects byte 0.
- S0, S1 and Y are purely combinational from the current inputs and state.

Test Plan (W=16):
- Reset: rst_n=0 with STEP=1 and I=DZ/ADD/RAMF -> after release, RAM[0..15]=0, Q=0, STATUS=0, EDB_OUT=0.
- Load and add:
  - EDB_IN=0x34, I=DZ/ADD/RAMF, B=1, C_IN=0, STEP=1 -> RAM[1]=0x3434.
  - Then I=AB/ADD/RAMF, A=1, B=1 -> RAM[1]=0x6868, STATUS sign=0 zero=0.
- Overflow and carry:
  - RAM[2]=0x7FFF, RAM[3]=0x0001, I=AB/ADD/NOP, A=2, B=3 -> S0=1, S1=1.
  - With STAT_LD=1 -> STATUS={0,1,1,0}.
  - Repeat with 0xFFFF+1 -> carry=1, zero=1.
- Shift linkage:
  - Q=0x8001, RAM[4]=0x0002, I=ZB/OR/RAMQU, B=4, Q0=1 -> RAM[4]=0x0005, Q=0x0003.
  - Then I=ZB/OR/RAMQD, R15=1 -> RAM[4]=0x8002, Q=0x8001.
- Readback: RAM[5]=0xABCD, I=ZA/OR/RAMA, A=5, B=6, BYTE_SEL=1, YHI_N=0, YLO_N=1, EDB_IN=0x12 -> the next edge gives EDB_OUT=0xA2. With STEP=0, RAM[6] is unchanged.
- Hold: STEP=0 with any I -> RAM, Q and STATUS unchanged over 10 cycles; EDB_OUT still tracks the readback.
